// File: rtl/wb_sched.sv
// Writeback sequencer for the multicycle MIPS datapath: turns one writeback command into
// register-file mux selects and RegWrite. Optional write counter under WB_SCHED_STATS_EN.
module wb_sched
`ifdef WB_SCHED_STATS_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd,
    input  logic [4:0]       rt_idx,
    input  logic [4:0]       rd_idx,
    input  logic             hold,
    output logic [1:0]       wreg_sel,
    output logic [1:0]       wdata_sel,
    output logic             reg_write,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef WB_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] wr_count
`endif
);

    typedef enum logic [1:0] {IDLE, W1, W2} state_t;

    state_t     state_reg, state_next;
    logic [1:0] wreg_sel_reg, wreg_sel_next;
    logic [1:0] wdata_sel_reg, wdata_sel_next;
    logic       en_reg, en_next;
    logic       pop_reg, pop_next;
    logic       nop_done_reg, nop_done_next;
    logic       err_reg, err_next;
    logic       accept;

    assign accept = cmd_valid && (state_reg == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wreg_sel_reg  <= 2'b00;
            wdata_sel_reg <= 2'b00;
            en_reg        <= 1'b0;
            pop_reg       <= 1'b0;
            nop_done_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wreg_sel_reg  <= wreg_sel_next;
            wdata_sel_reg <= wdata_sel_next;
            en_reg        <= en_next;
            pop_reg       <= pop_next;
            nop_done_reg  <= nop_done_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wreg_sel_next  = wreg_sel_reg;
        wdata_sel_next = wdata_sel_reg;
        en_next        = en_reg;
        pop_next       = pop_reg;
        nop_done_next  = 1'b0;
        err_next       = err_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    // en_next captures zero-register suppression of the first write at accept time
                    case (cmd)
                        3'b000: nop_done_next = 1'b1;
                        3'b001: begin
                            state_next = W1; pop_next = 1'b0; en_next = (rt_idx != 5'd0);
                            wreg_sel_next = 2'b00; wdata_sel_next = 2'b01;
                        end
                        3'b010: begin
                            state_next = W1; pop_next = 1'b0; en_next = (rd_idx != 5'd0);
                            wreg_sel_next = 2'b11; wdata_sel_next = 2'b00;
                        end
                        3'b011: begin
                            state_next = W1; pop_next = 1'b0; en_next = 1'b1;
                            wreg_sel_next = 2'b10; wdata_sel_next = 2'b10;
                        end
                        3'b100: begin
                            state_next = W1; pop_next = 1'b0; en_next = 1'b1;
                            wreg_sel_next = 2'b01; wdata_sel_next = 2'b11;
                        end
                        3'b101: begin
                            state_next = W1; pop_next = 1'b1; en_next = (rt_idx != 5'd0);
                            wreg_sel_next = 2'b00; wdata_sel_next = 2'b01;
                        end
                        3'b110: begin
                            state_next = W1; pop_next = 1'b0; en_next = (rd_idx != 5'd0);
                            wreg_sel_next = 2'b11; wdata_sel_next = 2'b10;
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            W1: begin
                if (!hold) begin
                    if (pop_reg) begin
                        state_next     = W2;
                        wreg_sel_next  = 2'b01;
                        wdata_sel_next = 2'b11;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            W2: begin
                if (!hold) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // hold acts within the current cycle so a stalled write never reaches the register file
    assign busy      = (state_reg != IDLE);
    assign cmd_ready = ~busy;
    assign wreg_sel  = wreg_sel_reg;
    assign wdata_sel = wdata_sel_reg;
    assign err       = err_reg;
    assign reg_write = ~hold && (((state_reg == W1) && en_reg) || (state_reg == W2));
    assign done      = nop_done_reg ||
                       (~hold && (((state_reg == W1) && !pop_reg) || (state_reg == W2)));

`ifdef WB_SCHED_STATS_EN
    logic [CNT_W-1:0] wr_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wr_count_reg <= '0;
        else if (reg_write && !(&wr_count_reg))
            wr_count_reg <= wr_count_reg + 1'b1;
    end

    assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_wb_sched.sv
// Directed, table-driven bench for wb_sched: command vectors plus hold, illegal-code,
// mid-command reset and (when enabled) write-counter sequences.
module tb_wb_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic [4:0] rt_idx;
    logic [4:0] rd_idx;
    logic       hold;
    logic [1:0] wreg_sel;
    logic [1:0] wdata_sel;
    logic       reg_write;
    logic       busy;
    logic       done;
    logic       err;
`ifdef WB_SCHED_STATS_EN
    logic [15:0] wr_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_sched dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .rt_idx    (rt_idx),
        .rd_idx    (rd_idx),
        .hold      (hold),
        .wreg_sel  (wreg_sel),
        .wdata_sel (wdata_sel),
        .reg_write (reg_write),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef WB_SCHED_STATS_EN
        ,
        .wr_count  (wr_count)
`endif
    );

    typedef struct {
        logic [2:0] cmd;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [1:0] wreg;
        logic [1:0] wdata;
        logic       we;
        logic       pop;
        logic       nop;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive a command for one cycle; returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] c, input logic [4:0] rt, input logic [4:0] rd);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd = c;
        rt_idx = rt;
        rd_idx = rd;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = 3'b111;
        rt_idx = 5'd31;
        rd_idx = 5'd31;
        #1;
    endtask

    initial begin
        vecs[0] = '{3'b010, 5'd0, 5'd5,  2'b11, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{3'b101, 5'd8, 5'd0,  2'b00, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{3'b001, 5'd3, 5'd0,  2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{3'b011, 5'd0, 5'd0,  2'b10, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3'b100, 5'd0, 5'd0,  2'b01, 2'b11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{3'b110, 5'd0, 5'd12, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{3'b001, 5'd0, 5'd7,  2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'b101, 5'd0, 5'd0,  2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{3'b110, 5'd9, 5'd0,  2'b11, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{3'b000, 5'd4, 5'd4,  2'b00, 2'b00, 1'b0, 1'b0, 1'b1};

        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd = 3'b000;
        rt_idx = 5'd0;
        rd_idx = 5'd0;
        hold = 1'b0;
        #1;
        chk("rst_wreg", wreg_sel, 0);
        chk("rst_wdata", wdata_sel, 0);
        chk("rst_we", reg_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ready", cmd_ready, 1);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].cmd, vecs[i].rt, vecs[i].rd);
            $display("vec %0d cmd=%0d rt=%0d rd=%0d wreg=%0d wdata=%0d we=%0b done=%0b",
                     i, vecs[i].cmd, vecs[i].rt, vecs[i].rd, wreg_sel, wdata_sel, reg_write, done);
            if (vecs[i].nop) begin
                chk($sformatf("v%0d_nop_done", i), done, 1);
                chk($sformatf("v%0d_nop_we", i), reg_write, 0);
                chk($sformatf("v%0d_nop_busy", i), busy, 0);
            end else begin
                chk($sformatf("v%0d_wreg", i), wreg_sel, vecs[i].wreg);
                chk($sformatf("v%0d_wdata", i), wdata_sel, vecs[i].wdata);
                chk($sformatf("v%0d_we", i), reg_write, vecs[i].we);
                chk($sformatf("v%0d_busy", i), busy, 1);
                chk($sformatf("v%0d_done1", i), done, vecs[i].pop ? 0 : 1);
                if (vecs[i].pop) begin
                    @(negedge clk);
                    #1;
                    chk($sformatf("v%0d_w2_wreg", i), wreg_sel, 2'b01);
                    chk($sformatf("v%0d_w2_wdata", i), wdata_sel, 2'b11);
                    chk($sformatf("v%0d_w2_we", i), reg_write, 1);
                    chk($sformatf("v%0d_w2_done", i), done, 1);
                end
            end
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_idle_ready", i), cmd_ready, 1);
            chk($sformatf("v%0d_idle_we", i), reg_write, 0);
            chk($sformatf("v%0d_idle_done", i), done, 0);
        end

        // LINK held for three cycles
        @(negedge clk);
        hold = 1'b1;
        issue(3'b011, 5'd0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d_we", k), reg_write, 0);
            chk($sformatf("hold%0d_busy", k), busy, 1);
            chk($sformatf("hold%0d_done", k), done, 0);
            $display("hold cycle %0d we=%0b busy=%0b", k, reg_write, busy);
            @(negedge clk);
            if (k == 2) hold = 1'b0;
            #1;
        end
        chk("hold_rel_wreg", wreg_sel, 2'b10);
        chk("hold_rel_wdata", wdata_sel, 2'b10);
        chk("hold_rel_we", reg_write, 1);
        chk("hold_rel_done", done, 1);
        @(negedge clk);
        #1;
        chk("hold_idle_busy", busy, 0);

        // illegal command sets sticky err
        issue(3'b111, 5'd1, 5'd1);
        $display("illegal err=%0b we=%0b done=%0b busy=%0b", err, reg_write, done, busy);
        chk("ill_err", err, 1);
        chk("ill_we", reg_write, 0);
        chk("ill_done", done, 0);
        chk("ill_busy", busy, 0);
        @(negedge clk);
        issue(3'b010, 5'd0, 5'd6);
        chk("ill_sticky_we", reg_write, 1);
        chk("ill_sticky_err", err, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ill_rst_err", err, 0);
        @(negedge clk);
        reset = 1'b1;

        // reset during POP W1 aborts without the $sp write
        issue(3'b101, 5'd8, 5'd0);
        chk("abort_w1_we", reg_write, 1);
        reset = 1'b0;
        #1;
        $display("abort we=%0b busy=%0b wreg=%0d wdata=%0d", reg_write, busy, wreg_sel, wdata_sel);
        chk("abort_we", reg_write, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wreg", wreg_sel, 0);
        chk("abort_wdata", wdata_sel, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_post_we", reg_write, 0);
        chk("abort_post_done", done, 0);
        chk("abort_post_ready", cmd_ready, 1);

`ifdef WB_SCHED_STATS_EN
        chk("cnt_after_rst", wr_count, 0);
        issue(3'b010, 5'd0, 5'd5);
        @(negedge clk);
        issue(3'b011, 5'd0, 5'd0);
        @(negedge clk);
        issue(3'b100, 5'd0, 5'd0);
        @(negedge clk);
        #1;
        $display("wr_count=%0d", wr_count);
        chk("cnt_three", wr_count, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
